// File: rtl/ber_pkg.sv
// rtl/ber_pkg.sv - shared state encoding and constants for the BER run controller
package ber_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_PRIME = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAIL  = 3'd6
    } ber_state_t;

    localparam int MAX_ERR_PER_WORD = 32;
    localparam int LANE_W           = 4;
    localparam int ERR_BITS_W       = 6;

    // A 32-bit word cannot carry more than 32 bit errors; larger reports are clamped.
    function automatic logic [ERR_BITS_W-1:0] clamp_err(input logic [ERR_BITS_W-1:0] bits);
        if (bits > ERR_BITS_W'(MAX_ERR_PER_WORD))
            return ERR_BITS_W'(MAX_ERR_PER_WORD);
        return bits;
    endfunction

endpackage

// File: rtl/ber_sat_acc.sv
// rtl/ber_sat_acc.sv - saturating accumulator with synchronous clear
module ber_sat_acc #(
    parameter int W    = 8,
    parameter int IN_W = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [IN_W-1:0] inc,
    output logic [W-1:0]    acc
);

    logic [W:0] sum;

    assign sum = {1'b0, acc} + {{(W + 1 - IN_W){1'b0}}, inc};

    // Add the increment, pinning at all-ones once the carry-out shows an overflow.
    always_ff @(posedge clk) begin
        if (rst || clr)
            acc <= '0;
        else if (en)
            acc <= sum[W] ? {W{1'b1}} : sum[W-1:0];
    end

endmodule

// File: rtl/ber_test_ctrl.sv
// rtl/ber_test_ctrl.sv - BER tester run controller: load, lock, run, drain, statistics
module ber_test_ctrl
    import ber_pkg::*;
#(
    parameter int CNT_W        = 48,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int CHK_LAT      = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [LANE_W-1:0]     lane_mask_in,
    input  logic [CNT_W-1:0]      word_target_in,
    input  logic                  chk_lock_in,
    input  logic                  chk_err_valid_in,
    input  logic [ERR_BITS_W-1:0] chk_err_bits_in,
    output logic                  gen_load_out,
    output logic                  gen_en_out,
    output logic [LANE_W-1:0]     byte_control_out,
    output logic                  chk_en_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  fail_out,
    output logic [CNT_W-1:0]      word_cnt_out,
    output logic [CNT_W-1:0]      err_cnt_out,
    output logic [7:0]            lock_loss_out
);

    // One timer serves both the PRIME lock window and the DRAIN countdown.
    localparam int TMR_W = $clog2(LOCK_TIMEOUT + CHK_LAT) + 1;

    ber_state_t         state;
    ber_state_t         state_next;
    logic [TMR_W-1:0]   timer;
    logic [LANE_W-1:0]  mask_q;
    logic [CNT_W-1:0]   target_q;
    logic               lock_prev;
    logic               start_ok;
    logic               load_now;
    logic [LANE_W-1:0]  mask_d;
    logic               busy_d;
    logic               err_en;
    logic               loss_en;

    assign start_ok = start_in && !abort_in && (word_target_in != '0) && (lane_mask_in != '0);
    assign load_now = (state_next == ST_LOAD);
    assign mask_d   = load_now ? lane_mask_in : mask_q;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; abort from any active or terminal state returns to IDLE.
    always_comb begin
        state_next = state;
        busy_d     = 1'b0;
        if (abort_in && state != ST_IDLE) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_FAIL: if (start_ok) state_next = ST_LOAD;
                ST_LOAD:  state_next = ST_PRIME;
                ST_PRIME: begin
                    if (chk_lock_in)
                        state_next = ST_RUN;
                    else if (timer == TMR_W'(LOCK_TIMEOUT - 1))
                        state_next = ST_FAIL;
                end
                ST_RUN:   if (word_cnt_out == target_q - CNT_W'(1)) state_next = ST_DRAIN;
                ST_DRAIN: if (timer == TMR_W'(CHK_LAT - 1)) state_next = ST_DONE;
                default:  state_next = ST_IDLE;
            endcase
        end
        busy_d = (state_next == ST_LOAD) || (state_next == ST_PRIME) ||
                 (state_next == ST_RUN)  || (state_next == ST_DRAIN);
    end

    // Run parameters are captured only when a qualified start is accepted.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mask_q   <= '0;
            target_q <= '0;
        end else if (load_now) begin
            mask_q   <= lane_mask_in;
            target_q <= word_target_in;
        end
    end

    // Timer counts while in PRIME or DRAIN and is zero on entry to either.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            timer <= '0;
        else if (state == ST_PRIME || state == ST_DRAIN)
            timer <= timer + TMR_W'(1);
        else
            timer <= '0;
    end

    // Word counter: cleared in LOAD, advances every RUN cycle unless aborting.
    always_ff @(posedge clk_in) begin
        if (rst_in || state == ST_LOAD)
            word_cnt_out <= '0;
        else if (state == ST_RUN && !abort_in)
            word_cnt_out <= word_cnt_out + CNT_W'(1);
    end

    // Previous lock level, for falling-edge detection.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            lock_prev <= 1'b0;
        else
            lock_prev <= chk_lock_in;
    end

    assign err_en  = (state == ST_RUN || state == ST_DRAIN) && chk_err_valid_in && !abort_in;
    assign loss_en = (state == ST_RUN) && lock_prev && !chk_lock_in && !abort_in;

    ber_sat_acc #(.W(CNT_W), .IN_W(ERR_BITS_W)) u_err_acc (
        .clk (clk_in),
        .rst (rst_in),
        .clr (state == ST_LOAD),
        .en  (err_en),
        .inc (clamp_err(chk_err_bits_in)),
        .acc (err_cnt_out)
    );

    ber_sat_acc #(.W(8), .IN_W(1)) u_loss_acc (
        .clk (clk_in),
        .rst (rst_in),
        .clr (state == ST_LOAD),
        .en  (loss_en),
        .inc (1'b1),
        .acc (lock_loss_out)
    );

    // Control outputs registered from the next state so they line up with the state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            gen_load_out     <= 1'b0;
            gen_en_out       <= 1'b0;
            chk_en_out       <= 1'b0;
            byte_control_out <= '0;
            busy_out         <= 1'b0;
            done_out         <= 1'b0;
            fail_out         <= 1'b0;
        end else begin
            gen_load_out     <= (state_next == ST_LOAD);
            gen_en_out       <= (state_next == ST_PRIME) || (state_next == ST_RUN);
            chk_en_out       <= (state_next == ST_PRIME) || (state_next == ST_RUN) ||
                                (state_next == ST_DRAIN);
            byte_control_out <= busy_d ? mask_d : '0;
            busy_out         <= busy_d;
            done_out         <= (state_next == ST_DONE);
            fail_out         <= (state_next == ST_FAIL);
        end
    end

endmodule
